// File: rtl/check_slider_path.sv
// Multi-cycle path checker for sliding pieces (rook, bishop, queen).
// Walks source->destination one square per clock, stopping at the first blocker.
//
// state | meaning
// IDLE  | waiting for a request; pattern check happens on accept
// STEP  | examining board square at cur, advancing by dir
// DONE  | one-cycle result pulse, then back to IDLE
module check_slider_path #(
  parameter int BOARD_DIM  = 8,
  parameter int COORD_W    = $clog2(BOARD_DIM),
  parameter int PIECE_W    = 4,
  parameter int EMPTY_CODE = 15,
  parameter int COLOR_BIT  = 3
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              valid_input,
  input  logic [1:0]                                        mode,
  input  logic                                              mover_color,
  input  logic [COORD_W-1:0]                                old_x,
  input  logic [COORD_W-1:0]                                old_y,
  input  logic [COORD_W-1:0]                                new_x,
  input  logic [COORD_W-1:0]                                new_y,
  input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][PIECE_W-1:0]  board_in,
  output logic                                              busy,
  output logic                                              valid_output,
  output logic                                              valid_move,
  output logic                                              blocked,
  output logic [COORD_W-1:0]                                block_x,
  output logic [COORD_W-1:0]                                block_y
);

  localparam int DW = COORD_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

  state_t r_state, w_next_state;

  logic [COORD_W-1:0] r_cur_x, r_cur_y, r_dest_x, r_dest_y;
  logic               r_dir_x_nz, r_dir_x_neg, r_dir_y_nz, r_dir_y_neg;
  logic               r_color;
  logic               r_valid_move, r_blocked;
  logic [COORD_W-1:0] r_block_x, r_block_y;

  logic [DW-1:0]      w_dx, w_dy;
  logic               w_rook, w_bishop, w_pattern_ok;
  logic [PIECE_W-1:0] w_sq;
  logic               w_sq_empty, w_at_dest;

  function automatic logic [COORD_W-1:0] f_step(input logic [COORD_W-1:0] c,
                                                input logic nz, input logic neg);
    if (!nz)     return c;
    else if (neg) return c - COORD_W'(1);
    else          return c + COORD_W'(1);
  endfunction

  // Distances carry one extra bit so the subtraction never wraps.
  assign w_dx = (new_x >= old_x) ? ({1'b0, new_x} - {1'b0, old_x})
                                 : ({1'b0, old_x} - {1'b0, new_x});
  assign w_dy = (new_y >= old_y) ? ({1'b0, new_y} - {1'b0, old_y})
                                 : ({1'b0, old_y} - {1'b0, new_y});

  assign w_rook   = (w_dx == '0) != (w_dy == '0);
  assign w_bishop = (w_dx == w_dy) && (w_dx != '0);

  always_comb begin
    w_pattern_ok = 1'b0;
    case (mode)
      2'd0:    w_pattern_ok = w_rook;
      2'd1:    w_pattern_ok = w_bishop;
      2'd2:    w_pattern_ok = w_rook || w_bishop;
      default: w_pattern_ok = 1'b0;
    endcase
  end

  assign w_sq       = board_in[r_cur_y][r_cur_x];
  assign w_sq_empty = (w_sq == PIECE_W'(EMPTY_CODE));
  assign w_at_dest  = (r_cur_x == r_dest_x) && (r_cur_y == r_dest_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (valid_input) w_next_state = w_pattern_ok ? S_STEP : S_DONE;
      S_STEP: if (w_at_dest || !w_sq_empty) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    valid_output = 1'b0;
    case (r_state)
      S_STEP: busy = 1'b1;
      S_DONE: begin
        busy         = 1'b1;
        valid_output = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_dest_x     <= '0;
      r_dest_y     <= '0;
      r_dir_x_nz   <= 1'b0;
      r_dir_x_neg  <= 1'b0;
      r_dir_y_nz   <= 1'b0;
      r_dir_y_neg  <= 1'b0;
      r_color      <= 1'b0;
      r_valid_move <= 1'b0;
      r_blocked    <= 1'b0;
      r_block_x    <= '0;
      r_block_y    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid_input) begin
          r_valid_move <= 1'b0;
          r_blocked    <= 1'b0;
          r_block_x    <= '0;
          r_block_y    <= '0;
          r_dest_x     <= new_x;
          r_dest_y     <= new_y;
          r_color      <= mover_color;
          r_dir_x_nz   <= (new_x != old_x);
          r_dir_x_neg  <= (new_x < old_x);
          r_dir_y_nz   <= (new_y != old_y);
          r_dir_y_neg  <= (new_y < old_y);
          r_cur_x      <= f_step(old_x, new_x != old_x, new_x < old_x);
          r_cur_y      <= f_step(old_y, new_y != old_y, new_y < old_y);
        end
        S_STEP: begin
          if (w_at_dest) begin
            // Destination: legal if empty or holding an enemy piece.
            r_valid_move <= w_sq_empty || (w_sq[COLOR_BIT] != r_color);
          end else if (!w_sq_empty) begin
            r_blocked <= 1'b1;
            r_block_x <= r_cur_x;
            r_block_y <= r_cur_y;
          end else begin
            r_cur_x <= f_step(r_cur_x, r_dir_x_nz, r_dir_x_neg);
            r_cur_y <= f_step(r_cur_y, r_dir_y_nz, r_dir_y_neg);
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_move = r_valid_move;
  assign blocked    = r_blocked;
  assign block_x    = r_block_x;
  assign block_y    = r_block_y;

endmodule

// File: tb/tb_check_slider_path.sv
// Bench for check_slider_path: per-cycle compare against a path-walk model,
// directed literal cases, reset abort, and a BOARD_DIM=4 instance.
module tb_check_slider_path;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  logic                   vi = 1'b0;
  logic [1:0]             mode = 2'd0;
  logic                   color = 1'b0;
  logic [2:0]             ox = '0, oy = '0, nx = '0, ny = '0;
  logic [7:0][7:0][3:0]   b8;
  logic                   busy, vo, vm, bl;
  logic [2:0]             bx, by;

  logic                   vi4 = 1'b0;
  logic [1:0]             mode4 = 2'd0;
  logic                   color4 = 1'b0;
  logic [1:0]             ox4 = '0, oy4 = '0, nx4 = '0, ny4 = '0;
  logic [3:0][3:0][3:0]   b4;
  logic                   busy4, vo4, vm4, bl4;
  logic [1:0]             bx4, by4;

  int n_cmp = 0;
  int n_bad = 0;

  check_slider_path #(.BOARD_DIM(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .valid_input(vi), .mode(mode),
    .mover_color(color), .old_x(ox), .old_y(oy), .new_x(nx), .new_y(ny),
    .board_in(b8), .busy(busy), .valid_output(vo), .valid_move(vm),
    .blocked(bl), .block_x(bx), .block_y(by));

  check_slider_path #(.BOARD_DIM(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .valid_input(vi4), .mode(mode4),
    .mover_color(color4), .old_x(ox4), .old_y(oy4), .new_x(nx4), .new_y(ny4),
    .board_in(b4), .busy(busy4), .valid_output(vo4), .valid_move(vm4),
    .blocked(bl4), .block_x(bx4), .block_y(by4));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Path-walk reference: result and latency from the move rules.
  task automatic model_eval(input int md, input int col, input int x0, input int y0,
                            input int x1, input int y1, output int lat,
                            output int rvm, output int rbl, output int rbx, output int rby);
    int adx, ady, sx, sy, d, x, y;
    bit rook, bish, ok, stop;
    logic [3:0] sq;
    adx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ady = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x1 > x0) ? 1 : (x1 < x0) ? -1 : 0;
    sy = (y1 > y0) ? 1 : (y1 < y0) ? -1 : 0;
    rook = (adx == 0) != (ady == 0);
    bish = (adx == ady) && (adx != 0);
    case (md)
      0: ok = rook;
      1: ok = bish;
      2: ok = rook || bish;
      default: ok = 1'b0;
    endcase
    lat = 1; rvm = 0; rbl = 0; rbx = 0; rby = 0;
    if (ok) begin
      d = (adx > ady) ? adx : ady;
      lat = d + 1;
      stop = 1'b0;
      for (int k = 1; k <= d; k++) begin
        if (!stop) begin
          x = x0 + k * sx;
          y = y0 + k * sy;
          sq = b8[y][x];
          if (k == d) begin
            rvm = ((sq == 4'd15) || (sq[3] != col[0])) ? 1 : 0;
          end else if (sq != 4'd15) begin
            rbl = 1; rbx = x; rby = y; lat = k + 1; stop = 1'b1;
          end
        end
      end
    end
  endtask

  int m_left = 0;
  int p_vm = 0, p_bl = 0, p_bx = 0, p_by = 0;
  int s_vm = 0, s_bl = 0, s_bx = 0, s_by = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      s_vm = 0; s_bl = 0; s_bx = 0; s_by = 0;
    end else begin
      if (m_left > 0) m_left = m_left - 1;
      else if (vi) begin
        model_eval(int'(mode), int'(color), int'(ox), int'(oy), int'(nx), int'(ny),
                   m_left, p_vm, p_bl, p_bx, p_by);
        s_vm = 0; s_bl = 0; s_bx = 0; s_by = 0;
      end
      if (m_left == 1) begin
        s_vm = p_vm; s_bl = p_bl; s_bx = p_bx; s_by = p_by;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
    chk("valid_output", int'(vo), (m_left == 1) ? 1 : 0);
    chk("valid_move", int'(vm), s_vm);
    chk("blocked", int'(bl), s_bl);
    chk("block_x", int'(bx), s_bx);
    chk("block_y", int'(by), s_by);
  end

  task automatic run8(input int md, input int col, input int x0, input int y0,
                      input int x1, input int y1, output int lat,
                      output int rvm, output int rbl, output int rbx, output int rby);
    int n;
    bit got;
    @(posedge clk); #1;
    mode = 2'(md); color = col[0];
    ox = 3'(x0); oy = 3'(y0); nx = 3'(x1); ny = 3'(y1);
    vi = 1'b1;
    @(posedge clk); #1;
    vi = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (vo) got = 1'b1;
    end
    lat = got ? n : -1;
    rvm = int'(vm); rbl = int'(bl); rbx = int'(bx); rby = int'(by);
  endtask

  task automatic clear_b8();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        b8[y][x] = 4'd15;
  endtask

  initial begin
    int lat, rvm, rbl, rbx, rby, n;
    bit seen;
    int x0, y0, x1, y1, dd, sel;

    clear_b8();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        b4[y][x] = 4'd15;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid_output", int'(vo), 0);
    chk("rst_valid_move", int'(vm), 0);
    chk("rst_blocked", int'(bl), 0);
    chk("rst_block_xy", int'({bx, by}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run8(2, 0, 0, 0, 7, 7, lat, rvm, rbl, rbx, rby);
    chk("queen_diag_lat", lat, 8);
    chk("queen_diag_vm", rvm, 1);
    chk("queen_diag_bl", rbl, 0);

    b8[3][0] = 4'd2;
    run8(0, 0, 0, 0, 0, 7, lat, rvm, rbl, rbx, rby);
    chk("rook_block_lat", lat, 4);
    chk("rook_block_vm", rvm, 0);
    chk("rook_block_bl", rbl, 1);
    chk("rook_block_x", rbx, 0);
    chk("rook_block_y", rby, 3);
    clear_b8();

    run8(1, 0, 2, 2, 2, 5, lat, rvm, rbl, rbx, rby);
    chk("bishop_rookpat_lat", lat, 1);
    chk("bishop_rookpat_vm", rvm, 0);
    run8(3, 0, 1, 1, 3, 3, lat, rvm, rbl, rbx, rby);
    chk("mode3_lat", lat, 1);
    chk("mode3_vm", rvm, 0);
    run8(2, 0, 4, 4, 4, 4, lat, rvm, rbl, rbx, rby);
    chk("zero_move_lat", lat, 1);
    chk("zero_move_vm", rvm + rbl, 0);

    b8[6][5] = 4'd9;
    run8(0, 0, 5, 0, 5, 6, lat, rvm, rbl, rbx, rby);
    chk("enemy_dest_lat", lat, 7);
    chk("enemy_dest_vm", rvm, 1);
    b8[6][5] = 4'd1;
    run8(0, 0, 5, 0, 5, 6, lat, rvm, rbl, rbx, rby);
    chk("friend_dest_lat", lat, 7);
    chk("friend_dest_vm", rvm, 0);
    chk("friend_dest_bl", rbl, 0);
    clear_b8();

    // Abort a 7-step walk with reset in its third cycle.
    @(posedge clk); #1;
    mode = 2'd0; color = 1'b0; ox = 3'd0; oy = 3'd0; nx = 3'd0; ny = 3'd7;
    vi = 1'b1;
    @(posedge clk); #1;
    vi = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid_output", int'(vo), 0);
    chk("abort_result", int'({vm, bl, bx, by}), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (vo) seen = 1'b1;
    end
    chk("abort_no_pulse", int'(seen), 0);
    run8(0, 0, 0, 0, 0, 7, lat, rvm, rbl, rbx, rby);
    chk("after_abort_lat", lat, 8);
    chk("after_abort_vm", rvm, 1);

    // BOARD_DIM=4 instance, then a back-to-back request.
    @(posedge clk); #1;
    mode4 = 2'd2; ox4 = 2'd3; oy4 = 2'd0; nx4 = 2'd0; ny4 = 2'd3; vi4 = 1'b1;
    @(posedge clk); #1;
    vi4 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (vo4) seen = 1'b1;
    end
    chk("d4_queen_lat", seen ? n : -1, 4);
    chk("d4_queen_vm", int'(vm4), 1);
    #1;
    mode4 = 2'd0; ox4 = 2'd0; oy4 = 2'd0; nx4 = 2'd3; ny4 = 2'd0; vi4 = 1'b1;
    @(posedge clk); #1;
    chk("d4_idle_after_done", int'(busy4), 0);
    @(posedge clk); #1;
    vi4 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (vo4) seen = 1'b1;
    end
    chk("d4_b2b_lat", seen ? n : -1, 4);
    chk("d4_b2b_vm", int'(vm4), 1);

    // Randomized traffic; board changes only while the model is idle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (m_left == 0) begin
        if ($urandom_range(3) == 0)
          for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
              b8[y][x] = ($urandom_range(4) == 0) ? 4'($urandom_range(14)) : 4'd15;
        x0 = $urandom_range(7); y0 = $urandom_range(7);
        x1 = $urandom_range(7); y1 = $urandom_range(7);
        sel = $urandom_range(3);
        if (sel == 1) y1 = y0;
        else if (sel == 2) x1 = x0;
        else if (sel == 3) begin
          dd = (x1 > x0) ? x1 - x0 : x0 - x1;
          if (y0 + dd <= 7 && $urandom_range(1) == 0) y1 = y0 + dd;
          else if (y0 - dd >= 0) y1 = y0 - dd;
        end
        mode = 2'($urandom_range(3));
        color = 1'($urandom_range(1));
        ox = 3'(x0); oy = 3'(y0); nx = 3'(x1); ny = 3'(y1);
        vi = ($urandom_range(2) != 0);
      end else begin
        vi = 1'($urandom_range(1));
        ox = 3'($urandom_range(7)); ny = 3'($urandom_range(7));
        mode = 2'($urandom_range(3));
      end
    end
    @(posedge clk); #1;
    vi = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
